// File: rtl/expr_seq_pkg.sv
// Shared types and constants for the expression stimulus sequencer.
// Holds bus widths, FSM states, LFSR/MISR taps and operand field layout.
package expr_seq_pkg;

  localparam int OP_W      = 60;
  localparam int RES_W     = 90;
  localparam int CNT_W_DEF = 16;
  localparam int LFSR_W    = 64;
  localparam int SCNT_W    = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CAPTURE,
    S_FINISH
  } state_e;

  // x^64+x^63+x^61+x^60+1
  localparam logic [LFSR_W-1:0] LFSR_TAPS =
    64'hD800_0000_0000_0000;

  // x^90+x^89+x^5+x^3+1
  localparam logic [RES_W-1:0] MISR_TAPS =
    (90'h1 << 89) | (90'h1 << 88) | 90'h14;

  // Operand fields a0..a5, b0..b5, MSB first
  localparam int NUM_OPF = 12;
  localparam int OPF_W [NUM_OPF] =
    '{4, 5, 6, 4, 5, 6, 4, 5, 6, 4, 5, 6};
  localparam int OPF_LSB [NUM_OPF] =
    '{56, 51, 45, 41, 36, 30, 26, 21, 15, 11, 6, 0};

endpackage

// File: rtl/expr_seq_misr.sv
// Parameterised multiple-input signature register.
// Shifts left with XOR feedback from TAPS, then folds in d.
module expr_seq_misr
  import expr_seq_pkg::*;
#(
  parameter int           W    = RES_W,
  parameter logic [W-1:0] TAPS = MISR_TAPS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] sig
);

  logic [W-1:0] sig_q;
  logic [W-1:0] sig_d;
  logic         fb;

  always_comb begin
    fb    = ^(sig_q & TAPS);
    sig_d = sig_q;
    if (clr) begin
      sig_d = '0;
    end else if (en) begin
      sig_d = {sig_q[W-2:0], fb} ^ d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/expr_stim_sequencer.sv
// LFSR-driven stimulus sequencer with MISR signature capture
// for combinational expression blocks.
module expr_stim_sequencer
  import expr_seq_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_vec,
  input  logic [63:0]      seed,
  output logic [OP_W-1:0]  op_bus,
  input  logic [RES_W-1:0] y_in,
  output logic             busy,
  output logic             done,
  output logic [RES_W-1:0] signature,
  output logic [CNT_W-1:0] vec_count
);

  localparam logic [SCNT_W-1:0] SETTLE_M1 =
    SCNT_W'(SETTLE - 1);

  state_e             state_q, state_d;
  logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
  logic [LFSR_W-1:0]  lfsr_nx;
  logic [OP_W-1:0]    op_q, op_d;
  logic [SCNT_W-1:0]  scnt_q, scnt_d;
  logic [CNT_W-1:0]   vec_q, vec_d;
  logic [CNT_W-1:0]   vec_inc;
  logic [CNT_W-1:0]   nv_q, nv_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               sig_clr;
  logic               sig_en;

  assign lfsr_nx = {lfsr_q[LFSR_W-2:0],
                    ^(lfsr_q & LFSR_TAPS)};
  assign vec_inc = vec_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    op_d    = op_q;
    scnt_d  = scnt_q;
    vec_d   = vec_q;
    nv_d    = nv_q;
    sig_clr = 1'b0;
    sig_en  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          nv_d    = num_vec;
          vec_d   = '0;
          sig_clr = 1'b1;
          if (num_vec != '0) begin
            lfsr_d  = (seed == '0) ? 64'd1 : seed;
            op_d    = lfsr_d[OP_W-1:0];
            scnt_d  = SETTLE_M1;
            state_d = S_SETTLE;
          end else begin
            state_d = S_FINISH;
          end
        end
      end
      S_SETTLE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (scnt_q == '0) begin
          state_d = S_CAPTURE;
        end else begin
          scnt_d = scnt_q - SCNT_W'(1);
        end
      end
      S_CAPTURE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          sig_en = 1'b1;
          vec_d  = vec_inc;
          lfsr_d = lfsr_nx;
          op_d   = lfsr_nx[OP_W-1:0];
          if (vec_inc == nv_q) begin
            state_d = S_FINISH;
          end else begin
            scnt_d  = SETTLE_M1;
            state_d = S_SETTLE;
          end
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d == S_SETTLE) ||
             (state_d == S_CAPTURE);
    done_d = (state_d == S_FINISH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      lfsr_q  <= 64'd1;
      op_q    <= '0;
      scnt_q  <= '0;
      vec_q   <= '0;
      nv_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      op_q    <= op_d;
      scnt_q  <= scnt_d;
      vec_q   <= vec_d;
      nv_q    <= nv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  expr_seq_misr #(
    .W    (RES_W),
    .TAPS (MISR_TAPS)
  ) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (sig_clr),
    .en    (sig_en),
    .d     (y_in),
    .sig   (signature)
  );

  assign op_bus    = op_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign vec_count = vec_q;

endmodule

// File: tb/tb_expr_stim_sequencer.sv
// Directed bench for expr_stim_sequencer: vector table plus
// abort and mid-run reset sequences on SETTLE=1 and SETTLE=3.
module tb_expr_stim_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        start1 = 1'b0, abort1 = 1'b0;
  logic [15:0] nv1 = '0;
  logic [63:0] seed1 = '0;
  logic [59:0] op1;
  logic [89:0] y1;
  logic        busy1, done1;
  logic [89:0] sig1;
  logic [15:0] vc1;
  int          mode1 = 0;

  logic        start3 = 1'b0, abort3 = 1'b0;
  logic [15:0] nv3 = '0;
  logic [63:0] seed3 = '0;
  logic [59:0] op3;
  logic [89:0] y3 = '1;
  logic        busy3, done3;
  logic [89:0] sig3;
  logic [15:0] vc3;

  int errors = 0;
  int checks = 0;
  int done1_n = 0;
  int done3_n = 0;
  int busy1_n = 0;

  always #5 clk = ~clk;

  function automatic logic [89:0] yfun(input logic [59:0] o);
    return {o[29:0], o} ^ {o, o[59:30]};
  endfunction

  function automatic logic [89:0] m_misr(input logic [89:0] s,
                                         input logic [89:0] y);
    logic fb;
    fb = s[89] ^ s[88] ^ s[4] ^ s[2];
    return {s[88:0], fb} ^ y;
  endfunction

  function automatic logic [63:0] m_lfsr(input logic [63:0] l);
    return {l[62:0], l[63] ^ l[62] ^ l[60] ^ l[59]};
  endfunction

  function automatic logic [89:0] model_sig(input int n,
                                            input logic [63:0] sd);
    logic [63:0] l;
    logic [89:0] s;
    l = (sd == 0) ? 64'd1 : sd;
    s = '0;
    for (int k = 0; k < n; k++) begin
      s = m_misr(s, yfun(l[59:0]));
      l = m_lfsr(l);
    end
    return s;
  endfunction

  always_comb
    y1 = (mode1 == 0) ? 90'd0 :
         (mode1 == 1) ? {90{1'b1}} : yfun(op1);

  always @(negedge clk) begin
    if (done1) done1_n++;
    if (done3) done3_n++;
    if (busy1) busy1_n++;
  end

  expr_stim_sequencer #(.CNT_W(16), .SETTLE(1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start1),
    .abort     (abort1),
    .num_vec   (nv1),
    .seed      (seed1),
    .op_bus    (op1),
    .y_in      (y1),
    .busy      (busy1),
    .done      (done1),
    .signature (sig1),
    .vec_count (vc1)
  );

  expr_stim_sequencer #(.CNT_W(16), .SETTLE(3)) u_dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start3),
    .abort     (abort3),
    .num_vec   (nv3),
    .seed      (seed3),
    .op_bus    (op3),
    .y_in      (y3),
    .busy      (busy3),
    .done      (done3),
    .signature (sig3),
    .vec_count (vc3)
  );

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic run1(input logic [15:0] n,
                      input logic [63:0] sd,
                      input int md,
                      output int dcyc,
                      output logic [59:0] op_first,
                      output logic busy_first,
                      output logic busy_done);
    int cyc;
    @(negedge clk);
    nv1 = n; seed1 = sd; mode1 = md; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    op_first = op1;
    busy_first = busy1;
    busy_done = 1'b1;
    dcyc = -1;
    cyc = 1;
    while (dcyc < 0 && cyc < 200) begin
      if (done1) begin
        dcyc = cyc;
        busy_done = busy1;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
  endtask

  typedef struct {
    logic [15:0] n;
    logic [63:0] seed;
    int          mode;
    logic [89:0] sig;
    logic [15:0] cnt;
    int          dcyc;
    logic [59:0] op;
    bit          chk_op;
  } vec_t;

  vec_t tv[7];

  initial begin
    int          dc, cyc, bstart;
    logic [59:0] of;
    logic        bf, bd;
    int          dsnap;

    tv[0] = '{16'd1, 64'd1, 0, 90'd0, 16'd1, 3, 60'h1, 1'b1};
    tv[1] = '{16'd2, 64'd1, 1, 90'h1, 16'd2, 5, 60'h1, 1'b1};
    tv[2] = '{16'd0, 64'd5, 0, 90'd0, 16'd0, 1, 60'h0, 1'b0};
    tv[3] = '{16'd1, 64'd0, 0, 90'd0, 16'd1, 3, 60'h1, 1'b1};
    tv[4] = '{16'd3, 64'd1, 1, ~90'h2, 16'd3, 7, 60'h1, 1'b1};
    tv[5] = '{16'd1, 64'hFFFF_0000_0000_1234, 0, 90'd0,
              16'd1, 3, 60'hFFF_0000_0000_1234, 1'b1};
    tv[6] = '{16'd5, 64'h0123_4567_89AB_CDEF, 2,
              model_sig(5, 64'h0123_4567_89AB_CDEF),
              16'd5, 11, 60'h123_4567_89AB_CDEF, 1'b1};

    #1;
    chk("rst_op", op1, 60'h0);
    chk("rst_busy", busy1, 1'b0);
    chk("rst_done", done1, 1'b0);
    chk("rst_sig", sig1, 90'h0);
    chk("rst_vc", vc1, 16'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      busy1_n = 0;
      run1(tv[i].n, tv[i].seed, tv[i].mode, dc, of, bf, bd);
      chk($sformatf("v%0d_done_cyc", i), dc, tv[i].dcyc);
      chk($sformatf("v%0d_sig", i), sig1, tv[i].sig);
      chk($sformatf("v%0d_vc", i), vc1, tv[i].cnt);
      chk($sformatf("v%0d_busy_at_done", i), bd, 1'b0);
      chk($sformatf("v%0d_busy_c1", i), bf, tv[i].n != 0);
      if (tv[i].chk_op)
        chk($sformatf("v%0d_op_c1", i), of, tv[i].op);
      if (tv[i].n == 0)
        chk($sformatf("v%0d_busy_never", i), busy1_n, 0);
      @(negedge clk);
      chk($sformatf("v%0d_done_1cyc", i), done1, 1'b0);
    end

    // N=2 all-ones: intermediate signature and second operand
    @(negedge clk);
    nv1 = 16'd2; seed1 = 64'd1; mode1 = 1; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("n2_sig_v1", sig1, {90{1'b1}});
    chk("n2_op_v2", op1, 60'h2);
    repeat (2) @(negedge clk);
    chk("n2_done", done1, 1'b1);
    chk("n2_sig", sig1, 90'h1);
    repeat (3) @(negedge clk);
    chk("n2_sig_hold", sig1, 90'h1);

    // Abort on second CAPTURE with SETTLE=3
    dsnap = done3_n;
    @(negedge clk);
    nv3 = 16'd4; seed3 = 64'd1; start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    repeat (7) @(negedge clk);
    abort3 = 1'b1;
    @(negedge clk);
    abort3 = 1'b0;
    chk("ab_busy", busy3, 1'b0);
    chk("ab_vc", vc3, 16'd1);
    chk("ab_sig", sig3, {90{1'b1}});
    repeat (3) @(negedge clk);
    chk("ab_no_done", done3_n, dsnap);

    // Restart after abort runs all four vectors
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    bstart = 1;
    chk("rs_busy_c1", busy3, 1'b1);
    chk("rs_op_c1", op3, 60'h1);
    dc = -1;
    cyc = 1;
    while (dc < 0 && cyc < 200) begin
      if (done3) dc = cyc;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("rs_done_after_busy", dc - bstart, 16);
    chk("rs_vc", vc3, 16'd4);
    chk("rs_sig", sig3, 90'h5);

    // Reset during the third vector's CAPTURE
    @(negedge clk);
    nv1 = 16'd5; seed1 = 64'd1; mode1 = 1; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (5) @(negedge clk);
    chk("mr_busy_pre", busy1, 1'b1);
    chk("mr_vc_pre", vc1, 16'd2);
    dsnap = done1_n;
    rst_n = 1'b0;
    #1;
    chk("mr_op", op1, 60'h0);
    chk("mr_busy", busy1, 1'b0);
    chk("mr_done", done1, 1'b0);
    chk("mr_sig", sig1, 90'h0);
    chk("mr_vc", vc1, 16'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("mr_no_done", done1_n, dsnap);
    chk("mr_idle_busy", busy1, 1'b0);

    run1(16'd2, 64'd1, 1, dc, of, bf, bd);
    chk("mr_fresh_done_cyc", dc, 5);
    chk("mr_fresh_op", of, 60'h1);
    chk("mr_fresh_sig", sig1, 90'h1);
    chk("mr_fresh_vc", vc1, 16'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/expr_stim_sequencer.md
# expr_stim_sequencer

Self-checking stimulus sequencer for the generated combinational expression blocks in the regression suite. It drives the 60-bit operand bus (a0..a5, b0..b5) of one expression instance from a 64-bit LFSR and waits a programmable settle time. It then folds the 90-bit result `y` into a 90-bit MISR signature, repeating for a requested number of vectors. It sits between the regression testbench/host and the expression datapath, so the design under test is compared by signature instead of per-vector output.

## Interface
- `OP_W`, 60: operand bus width. Packing, MSB first: a0[3:0], a1[4:0], a2[5:0], a3[3:0], a4[4:0], a5[5:0], b0..b5 with the same widths.
- `RES_W`, 90: result/signature width.
- `CNT_W`, 16: vector counter width.
- `SETTLE`, 1: cycles the operands are held before capture. Legal range is 1..15.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a run. Sampled only in IDLE.
- `abort`  in  1  synchronous run cancel.
- `num_vec`  in  CNT_W  vector count, sampled on start.
- `seed`  in  64  LFSR seed, sampled on start.
- `op_bus`  out  OP_W  operands to the expression block.
- `y_in`  in  RES_W  expression result.
- `busy`  out  1  run in progress.
- `done`  out  1  one-cycle completion pulse.
- `signature`  out  RES_W  MISR value. Held after done until the next start.
- `vec_count`  out  CNT_W  vectors captured so far.

## Operation
- States are IDLE, SETTLE, CAPTURE and FINISH.
- **IDLE**
  - `start`=1 and `num_vec`≠0: load lfsr←seed, or lfsr←1 if seed==0. Clear signature and vec_count, set settle_cnt←SETTLE-1, go to SETTLE.
  - `start`=1 and `num_vec`==0: go to FINISH. Signature is cleared to 0.
- **SETTLE**
  - `op_bus`=lfsr[59:0] is held stable.
  - settle_cnt==0 → CAPTURE; otherwise decrement settle_cnt.
- **CAPTURE**
  - signature←{sig[88:0], fb}^y_in, where fb=sig[89]^sig[88]^sig[4]^sig[2] (polynomial x^90+x^89+x^5+x^3+1).
  - vec_count++.
  - lfsr←{lfsr[62:0], lfsr[63]^lfsr[62]^lfsr[60]^lfsr[59]} (polynomial x^64+x^63+x^61+x^60+1).
  - Next state is FINISH if the incremented vec_count==num_vec; otherwise SETTLE with settle_cnt←SETTLE-1.
- **FINISH**: done=1 for exactly one cycle, then IDLE.
- `busy`=1 in SETTLE and CAPTURE only.
- `abort`=1 in SETTLE or CAPTURE:
  - next state is IDLE with no done pulse;
  - signature and vec_count keep their partial values;
  - `abort` has priority over the CAPTURE update in that cycle.
- `start` while busy is ignored.
- `num_vec` and `seed` changes during a run are ignored.
- Counter arithmetic is unsigned modulo 2^CNT_W. num_vec=2^CNT_W-1 runs to completion with no wrap.

## Timing
- Reset values:
  - op_bus=0, busy=0, done=0, signature=0, vec_count=0;
  - internal lfsr=1, state IDLE.
- All outputs are registered. `op_bus` is driven from the lfsr register.
- If `start` is sampled at edge 0:
  - busy=1 and op_bus=seed[59:0] from cycle 1;
  - each vector takes SETTLE+1 cycles;
  - done is high in cycle 1+N·(SETTLE+1);
  - busy=0 in that cycle.
- With num_vec=0, done is high in cycle 1.
- `y_in` is sampled only on the CAPTURE edge. It must be a combinational function of `op_bus`.
- Reset asserted mid-run returns the block to reset values immediately. No done pulse is produced.

## Structure
- Package `expr_seq_pkg` holds:
  - OP_W, RES_W and the default CNT_W;
  - the state enum;
  - LFSR and MISR tap constants;
  - operand field offset/width constants for a0..b5.
- Sub-module `expr_seq_misr` is the parameterised MISR (width and taps), so it can be reused for other result widths.
- The LFSR stays inline in the top.

## Test plan
- SETTLE=1, N=1, seed=1, y_in=0 → op_bus=60'h1 in cycles 1–2; done in cycle 3; signature=0; vec_count=1.
- SETTLE=1, N=2, seed=1, y_in=all-ones:
  - signature=all-ones after vector 1;
  - the second vector has op_bus=60'h2;
  - final signature=90'h1, done in cycle 5.
- start with num_vec=0 → done in cycle 1, busy never asserts, signature=0.
- seed=0, N=1 → op_bus=60'h1, identical to the seed=1 run.
- SETTLE=3, N=4:
  - assert abort in the second CAPTURE cycle → IDLE, vec_count=1, no done;
  - a subsequent start runs a full 4 vectors, with done 16 cycles after busy asserts.
- Drop rst_n mid-run at vector 3 → all outputs at reset values in the same cycle; no done; a start after release behaves as a fresh run.
